// File: rtl/sevenseg_capture_if.sv
// Seven-segment snoop bus: wire-side segment/select pins in, reconstructed digits and status pulses out.
// The dp lane exists only when SEVENSEG_CAPTURE_DP_EN is defined.
interface sevenseg_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   sel_in;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic                    err;
`ifdef SEVENSEG_CAPTURE_DP_EN
  logic                    dp_in;
  logic [NUM_DIGITS-1:0]   dp_out;

  modport master (
    output seg_in, sel_in, dp_in,
    input  digits_out, digit_valid, frame_done, err, dp_out
  );
  modport slave (
    input  seg_in, sel_in, dp_in,
    output digits_out, digit_valid, frame_done, err, dp_out
  );
`else
  modport master (
    output seg_in, sel_in,
    input  digits_out, digit_valid, frame_done, err
  );
  modport slave (
    input  seg_in, sel_in,
    output digits_out, digit_valid, frame_done, err
  );
`endif
endinterface

// File: rtl/sevenseg_capture.sv
// Snoops a multiplexed seven-segment bus, commits a digit once the sample is stable for STABLE_CYCLES.
// Optional macro SEVENSEG_CAPTURE_DP_EN adds the dp_in/dp_out decimal-point lane.
module sevenseg_capture #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  sevenseg_capture_if.slave bus
);
`ifdef SEVENSEG_CAPTURE_DP_EN
  localparam int SW = 8 + NUM_DIGITS;
`else
  localparam int SW = 7 + NUM_DIGITS;
`endif
  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ARM  = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]           pin_w, samp_w;
  logic [SW-1:0]           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;
  logic                    same_w, commit_w, multi_w;
  logic [6:0]              seg_w;
  logic [NUM_DIGITS-1:0]   sel_w;
  logic [4:0]              dec_w;

`ifdef SEVENSEG_CAPTURE_DP_EN
  logic                    dp_w;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  assign pin_w      = {bus.dp_in, bus.sel_in, bus.seg_in};
  assign dp_w       = samp_w[SW-1];
  assign bus.dp_out = dp_q;
`else
  assign pin_w      = {bus.sel_in, bus.seg_in};
`endif

  // Polarity is normalised after the synchronizer so the flops see raw pins.
  assign samp_w = SEG_ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign seg_w  = samp_w[6:0];
  assign sel_w  = samp_w[7 +: NUM_DIGITS];

  assign same_w   = (samp_w == prev_q);
  assign commit_w = same_w && (cnt_q == CNT_ARM);
  assign multi_w  = (sel_w & (sel_w - 1'b1)) != '0;

  // Returns {hit, nibble}; hit=0 for anything outside the hex glyph set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h67:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign dec_w = decode(seg_w);

  always_comb begin
    if (!same_w)              cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    else                      cnt_d = cnt_q;
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    mask_d   = mask_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
    dp_d     = dp_q;
`endif
    if (commit_w && (sel_w != '0)) begin
      if (multi_w) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_w[i]) begin
            if (dec_w[4]) begin
              digits_d[4*i +: 4] = dec_w[3:0];
              valid_d[i]         = 1'b1;
            end else begin
              valid_d[i] = 1'b0;
              err_d      = (seg_w != 7'h00);
            end
            mask_d[i] = 1'b1;
`ifdef SEVENSEG_CAPTURE_DP_EN
            dp_d[i]   = dp_w;
`endif
          end
        end
        // Frame completes on the commit that fills the mask; the mask restarts empty.
        if (&mask_d) begin
          frame_d = 1'b1;
          mask_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      mask_q   <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
      dp_q     <= '0;
`endif
    end else begin
      sync1_q  <= pin_w;
      sync2_q  <= sync1_q;
      prev_q   <= samp_w;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
`ifdef SEVENSEG_CAPTURE_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed vector table, corner sequences, and random holds against a window model.
module tb_sevenseg_capture;
  localparam int N = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_capture_if #(.NUM_DIGITS(N)) bus ();
  sevenseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  sevenseg_capture_if #(.NUM_DIGITS(2)) bus_lo ();
  sevenseg_capture #(.NUM_DIGITS(2), .STABLE_CYCLES(3), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .bus(bus_lo)
  );

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] sel;
    int           hold;
    logic [15:0]  exp_dig;
    logic [N-1:0] exp_val;
    int           exp_err;
    int           exp_frm;
  } vec_t;

  int vec_cnt = 0;
  int bad_cnt = 0;

  // Model: history of pin words seen at each sampling edge, plus the architectural state.
  logic [6+N:0]  hist [$];
  logic [15:0]   m_dig;
  logic [N-1:0]  m_val, m_mask;
  logic          m_frm, m_err;
  int            err_seen, frm_seen;

  function automatic int glyph_index(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (GLYPH[k] == s) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S + 3; k++) hist.push_back('0);
    m_dig = '0; m_val = '0; m_mask = '0; m_frm = 1'b0; m_err = 1'b0;
  endtask

  // A value commits when it was sampled on S+1 consecutive edges ending two edges ago,
  // and the edge before that window saw something different.
  task automatic model_edge();
    int n, ones, idx, g;
    bit run;
    logic [6+N:0] v;
    logic [6:0] sg;
    logic [N-1:0] sl;
    while (hist.size() > S + 8) void'(hist.pop_front());
    n = hist.size() - 1;
    v = hist[n-2-S];
    run = 1'b1;
    for (int k = n - 1 - S; k <= n - 2; k++) if (hist[k] != v) run = 1'b0;
    m_frm = 1'b0;
    m_err = 1'b0;
    if (run && hist[n-3-S] != v) begin
      sg = v[6:0];
      sl = v[7 +: N];
      ones = $countones(sl);
      if (ones > 1) begin
        m_err = 1'b1;
      end else if (ones == 1) begin
        idx = 0;
        for (int k = 0; k < N; k++) if (sl[k]) idx = k;
        g = glyph_index(sg);
        if (g >= 0) begin
          m_dig[4*idx +: 4] = 4'(g);
          m_val[idx] = 1'b1;
        end else begin
          m_val[idx] = 1'b0;
          m_err = (sg != 7'h00);
        end
        m_mask[idx] = 1'b1;
        if (m_mask == '1) begin
          m_frm = 1'b1;
          m_mask = '0;
        end
      end
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic [N-1:0] sel);
    bus.seg_in = seg;
    bus.sel_in = sel;
    @(posedge clk);
    hist.push_back({sel, seg});
    model_edge();
    #1;
    chk("digits_out", 32'(bus.digits_out), 32'(m_dig));
    chk("digit_valid", 32'(bus.digit_valid), 32'(m_val));
    chk("frame_done", 32'(bus.frame_done), 32'(m_frm));
    chk("err", 32'(bus.err), 32'(m_err));
    err_seen += int'(bus.err);
    frm_seen += int'(bus.frame_done);
  endtask

  task automatic hold(input logic [6:0] seg, input logic [N-1:0] sel, input int len);
    for (int k = 0; k < len; k++) step(seg, sel);
  endtask

  task automatic do_reset();
    bus.seg_in = '0;
    bus.sel_in = '0;
    rst = 1'b1;
    #1;
    chk("reset_digits", 32'(bus.digits_out), 32'h0);
    chk("reset_valid", 32'(bus.digit_valid), 32'h0);
    chk("reset_pulses", {30'h0, bus.frame_done, bus.err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tab [12];

  initial begin
    tab[0]  = '{7'h7D, 4'b0001, 10, 16'h0006, 4'b0001, 0, 0};
    tab[1]  = '{7'h06, 4'b0001, 12, 16'h0001, 4'b0001, 0, 0};
    tab[2]  = '{7'h5B, 4'b0010, 12, 16'h0021, 4'b0011, 0, 0};
    tab[3]  = '{7'h4F, 4'b0100, 12, 16'h0321, 4'b0111, 0, 0};
    tab[4]  = '{7'h66, 4'b1000, 12, 16'h4321, 4'b1111, 0, 1};
    tab[5]  = '{7'h55, 4'b0100, 12, 16'h4321, 4'b1011, 1, 0};
    tab[6]  = '{7'h00, 4'b0010, 12, 16'h4321, 4'b1001, 0, 0};
    tab[7]  = '{7'h7F, 4'b0110, 12, 16'h4321, 4'b1001, 1, 0};
    tab[8]  = '{7'h77, 4'b0001, 40, 16'h432A, 4'b1001, 0, 0};
    tab[9]  = '{7'h3F, 4'b1000,  9, 16'h032A, 4'b1001, 0, 1};
    tab[10] = '{7'h3F, 4'b0001,  8, 16'h032A, 4'b1001, 0, 0};
    tab[11] = '{7'h00, 4'b0000, 12, 16'h032A, 4'b1001, 0, 0};

    bus_lo.seg_in = 7'h7F;
    bus_lo.sel_in = 2'b11;
`ifdef SEVENSEG_CAPTURE_DP_EN
    bus.dp_in    = 1'b0;
    bus_lo.dp_in = 1'b1;
`endif
    err_seen = 0;
    frm_seen = 0;

    // Exact latency: value held 10 edges, visible only after the 10th edge past the first sample.
    do_reset();
    hold(7'h7D, 4'b0001, 10);
    chk("latency_early", 32'(bus.digit_valid), 32'h0);
    step(7'h00, 4'b0000);
    chk("latency_exact", {16'(bus.digit_valid), bus.digits_out}, {16'h0001, 16'h0006});
    hold(7'h00, 4'b0000, 3);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      err_seen = 0;
      frm_seen = 0;
      hold(tab[i].seg, tab[i].sel, tab[i].hold);
      hold(7'h00, 4'b0000, 4);
      chk($sformatf("tab%0d_digits", i), 32'(bus.digits_out), 32'(tab[i].exp_dig));
      chk($sformatf("tab%0d_valid", i), 32'(bus.digit_valid), 32'(tab[i].exp_val));
      chk($sformatf("tab%0d_errs", i), 32'(err_seen), 32'(tab[i].exp_err));
      chk($sformatf("tab%0d_frames", i), 32'(frm_seen), 32'(tab[i].exp_frm));
    end

    // Glitching scan: never stable long enough to commit, then a clean hold does.
    for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? 7'h7F : 7'h3F, 4'b0010, 3);
    chk("toggle_nocommit", 32'(bus.digits_out), 32'h032A);
    hold(7'h3F, 4'b0010, 12);
    hold(7'h00, 4'b0000, 4);
    chk("toggle_then_stable", {16'(bus.digit_valid), bus.digits_out}, {16'h000B, 16'h030A});

    // Reset partway through a stability window: no late commit afterwards.
    hold(7'h5B, 4'b0100, 5);
    err_seen = 0;
    frm_seen = 0;
    do_reset();
    hold(7'h00, 4'b0000, 15);
    chk("midreset_valid", 32'(bus.digit_valid), 32'h0);
    chk("midreset_pulses", 32'(err_seen + frm_seen), 32'h0);

    // Random holds against the window model.
    for (int r = 0; r < 150; r++) begin
      logic [N-1:0] sl;
      logic [6:0] sg;
      case ($urandom_range(0, 3))
        0:       sl = '0;
        3:       sl = N'($urandom_range(0, (1 << N) - 1));
        default: sl = N'(1) << $urandom_range(0, N - 1);
      endcase
      case ($urandom_range(0, 3))
        0:       sg = 7'h00;
        1:       sg = 7'($urandom_range(0, 127));
        default: sg = GLYPH[$urandom_range(0, 15)];
      endcase
      hold(sg, sl, $urandom_range(1, 14));
    end

    // Active-low instance: inverted pins decode to digit 0 = 1.
    bus_lo.seg_in = ~7'h06;
    bus_lo.sel_in = ~2'b01;
`ifdef SEVENSEG_CAPTURE_DP_EN
    bus_lo.dp_in  = 1'b0;
`endif
    repeat (8) @(posedge clk);
    bus_lo.seg_in = 7'h7F;
    bus_lo.sel_in = 2'b11;
`ifdef SEVENSEG_CAPTURE_DP_EN
    bus_lo.dp_in  = 1'b1;
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("lo_digits", 32'(bus_lo.digits_out), 32'h01);
    chk("lo_valid", 32'(bus_lo.digit_valid), 32'h1);
`ifdef SEVENSEG_CAPTURE_DP_EN
    chk("lo_dp", 32'(bus_lo.dp_out), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
Reader side of the seven-segment display interface: samples a multiplexed seven-segment bus (segment lines plus one-hot digit select) driven by an external or on-board display driver, and reconstructs the displayed hex nibbles. Filters scan glitches by requiring a stable sample window before committing a digit. Used for loopback self-test of the display path and for snooping external boards' displays.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (>=1)
STABLE_CYCLES, 8, consecutive identical synchronized samples required to commit (>=1)
SEG_ACTIVE_LOW, 0, 1 = seg_in and sel_in are active-low on the wire; inverted after synchronization

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
seg_in  input  7  segment lines, bit0=a ... bit6=g
sel_in  input  NUM_DIGITS  digit select, one-hot when a digit is driven
digits_out  output  4*NUM_DIGITS  captured nibbles, digit i in bits [4i+3:4i]
digit_valid  output  NUM_DIGITS  bit i set = digit i holds a decoded, non-blank value
frame_done  output  1  one-cycle pulse when every digit has been committed since the previous pulse
err  output  1  one-cycle pulse on commit of an undecodable pattern or multi-hot select

Behaviour:
- Reset (async, rst=1): synchronizers, previous-sample register, stability counter, committed mask -> 0; digits_out=0, digit_valid=0, frame_done=0, err=0; commit logic armed.
- Input path: {sel_in, seg_in} through 2-flop synchronizer; optional inversion per SEG_ACTIVE_LOW applied after stage 2.
- Stability: counter compares synchronized sample with previous-cycle sample; equal -> increment, saturating at STABLE_CYCLES; different -> 0 and re-arm.
- Commit: occurs exactly once per stable value, on the cycle the counter reaches STABLE_CYCLES; no further commit until the sample changes.
- Latency: a value present on the pins from clock edge T on is reflected in registered outputs after edge T+STABLE_CYCLES+2; pulses asserted during that same cycle.
- Decode table (exact match, hex seg -> nibble): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 67->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
- On commit, by select:
  - sel=0: blanking interval, no effect, no err.
  - sel multi-hot: err pulse, no digit updated.
  - sel one-hot i, pattern in table: digits_out[i] <= nibble, digit_valid[i] <= 1, committed mask bit i set.
  - sel one-hot i, pattern 00: digit_valid[i] <= 0, nibble held, mask bit i set, no err.
  - sel one-hot i, any other pattern: digit_valid[i] <= 0, nibble held, mask bit i set, err pulse.
- frame_done: when committed mask (including the bit set this cycle) is all ones, pulse frame_done and clear mask in the same cycle.
- Re-commit of an already-set digit before the frame completes: nibble/valid updated; mask unaffected.
- Reset mid-window: counter and pending commit discarded; no pulse emitted.

Optional Feature:
SEVENSEG_CAPTURE_DP_EN: adds input dp_in (1 bit, same synchronizer/polarity handling, part of the stability compare) and output dp_out (NUM_DIGITS), bit i <= dp_in on any one-hot commit to digit i, reset 0; decode ignores dp. Without the macro: no dp ports; behaviour exactly as above.

Test Plan:
- Reset, then sel=0001, seg=7D held 10 cycles (STABLE_CYCLES=8) -> digits_out[3:0]=6, digit_valid=0001 exactly 10 edges after first sample; err=0.
- Scan 1,2,3,4 (seg 06,5B,4F,66) across sel 0001..1000, each held 12 cycles -> digits_out=16'h4321, digit_valid=1111, single frame_done on 4th commit.
- sel=0010 with seg 7F toggling to 3F every 3 cycles -> no commit, outputs unchanged; then seg 3F held 8+ -> digit1=0.
- sel=0100, seg=55 held -> err one pulse, digit_valid[2]=0, nibble held; sel=0110 held -> err pulse, no digit changes.
- Hold seg=77, sel=0001 for 40 cycles -> exactly one commit (digit0=A), no repeat pulses; assert rst mid-window on a later value -> all outputs 0 immediately, no pulse.
- SEG_ACTIVE_LOW=1: pins seg=~06, sel=~0001 held -> digit0=1, valid; with SEVENSEG_CAPTURE_DP_EN and dp pin low -> dp_out[0]=1.
